// File: rtl/deal_sequencer_pkg.sv
// Shared types and score constants for the baccarat round sequencer.
// Slot order encodes the deal order; the bench relies on the enum values.
package baccarat_pkg;

    typedef enum logic [1:0] {IDLE, DEAL, SETTLE, DONE} state_t;
    typedef enum logic [2:0] {P1, D1, P2, D2, P3, D3} slot_t;

    localparam logic [3:0] NATURAL_LO   = 4'd8;
    localparam logic [3:0] PLAYER_STAND = 4'd6;

    function automatic logic is_natural(input logic [3:0] score);
        return score >= NATURAL_LO;
    endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Card-source handshake, datapath strobes/scores and result outputs of the sequencer.
// master = sequencer side, slave = card source / datapath / display side.
interface deal_sequencer_if #(
    parameter int TALLY_W = 8
);
    logic               start;
    logic               card_valid;
    logic               card_req;
    logic               load_pcard1, load_pcard2, load_pcard3;
    logic               load_dcard1, load_dcard2, load_dcard3;
    logic [3:0]         pscore, dscore, pcard3;
    logic               busy;
    logic               round_done;
    logic               player_win_light, dealer_win_light;
    logic [TALLY_W-1:0] player_wins, dealer_wins, ties, rounds;

    modport master (
        input  start, card_valid, pscore, dscore, pcard3,
        output card_req, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3, busy, round_done,
               player_win_light, dealer_win_light,
               player_wins, dealer_wins, ties, rounds
    );

    modport slave (
        output start, card_valid, pscore, dscore, pcard3,
        input  card_req, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3, busy, round_done,
               player_win_light, dealer_win_light,
               player_wins, dealer_wins, ties, rounds
    );
endinterface

// File: rtl/deal_sequencer_third_card_rule.sv
// Dealer third-card tableau: purely combinational, evaluated after the player's third card.
// dscore >= 7 never draws.
module third_card_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       dealer_draws
);
    always_comb begin
        dealer_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (pcard3 != 4'd8);
            4'd4:             dealer_draws = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             dealer_draws = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             dealer_draws = (pcard3 == 4'd6) || (pcard3 == 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    end
endmodule

// File: rtl/deal_sequencer.sv
// Sequences one baccarat round: requests cards, steers them to slot registers, applies
// natural/third-card rules, then registers win lights and saturating tallies.
module deal_sequencer
    import baccarat_pkg::*;
#(
    parameter int TALLY_W   = 8,
    parameter int SETTLE_CY = 1
) (
    input  logic             slow_clock,
    input  logic             reset,
    deal_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(SETTLE_CY + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CY - 1);

    state_t           state;
    slot_t            slot;
    slot_t            next_slot;
    logic [CNT_W-1:0] settle_cnt;
    logic             go_done;
    logic             dealer_draws;
    logic             xfer;

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    third_card_rule u_rule (
        .dscore       (bus.dscore),
        .pcard3       (bus.pcard3),
        .dealer_draws (dealer_draws)
    );

    // Strobes follow the handshake in the same cycle so the datapath captures the offered card.
    assign xfer            = (state == DEAL) && bus.card_valid;
    assign bus.card_req    = (state == DEAL);
    assign bus.busy        = (state == DEAL) || (state == SETTLE);
    assign bus.load_pcard1 = xfer && (slot == P1);
    assign bus.load_dcard1 = xfer && (slot == D1);
    assign bus.load_pcard2 = xfer && (slot == P2);
    assign bus.load_dcard2 = xfer && (slot == D2);
    assign bus.load_pcard3 = xfer && (slot == P3);
    assign bus.load_dcard3 = xfer && (slot == D3);

    always_comb begin
        go_done   = 1'b0;
        next_slot = slot;
        case (slot)
            P1: next_slot = D1;
            D1: next_slot = P2;
            P2: next_slot = D2;
            D2: begin
                if (is_natural(bus.pscore) || is_natural(bus.dscore)) go_done = 1'b1;
                else if (bus.pscore < PLAYER_STAND)                   next_slot = P3;
                else if (bus.dscore < PLAYER_STAND)                   next_slot = D3;
                else                                                  go_done = 1'b1;
            end
            P3: begin
                if (dealer_draws) next_slot = D3;
                else              go_done = 1'b1;
            end
            default: go_done = 1'b1;
        endcase
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            slot                 <= P1;
            settle_cnt           <= '0;
            bus.round_done       <= 1'b0;
            bus.player_win_light <= 1'b0;
            bus.dealer_win_light <= 1'b0;
            bus.player_wins      <= '0;
            bus.dealer_wins      <= '0;
            bus.ties             <= '0;
            bus.rounds           <= '0;
        end else begin
            bus.round_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        bus.player_win_light <= 1'b0;
                        bus.dealer_win_light <= 1'b0;
                        slot                 <= P1;
                        state                <= DEAL;
                    end
                end
                DEAL: begin
                    if (bus.card_valid) begin
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else if (go_done) begin
                        state                <= DONE;
                        bus.round_done       <= 1'b1;
                        bus.player_win_light <= (bus.pscore >= bus.dscore);
                        bus.dealer_win_light <= (bus.pscore <= bus.dscore);
                        bus.rounds           <= sat_inc(bus.rounds);
                        if (bus.pscore > bus.dscore)      bus.player_wins <= sat_inc(bus.player_wins);
                        else if (bus.pscore < bus.dscore) bus.dealer_wins <= sat_inc(bus.dealer_wins);
                        else                              bus.ties        <= sat_inc(bus.ties);
                    end else begin
                        slot  <= next_slot;
                        state <= DEAL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench: a TALLY_W=8 and a TALLY_W=2 sequencer run in lockstep on scripted scores.
module tb_deal_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   strobe_total = 0;
    int   multi_strobe = 0;
    int   snap;
    int   stall_ok;

    deal_sequencer_if #(.TALLY_W(8)) dif ();
    deal_sequencer_if #(.TALLY_W(2)) sif ();

    deal_sequencer #(.TALLY_W(8), .SETTLE_CY(1)) dut (
        .slow_clock (clk), .reset (rst), .bus (dif));
    deal_sequencer #(.TALLY_W(2), .SETTLE_CY(1)) dut_sat (
        .slow_clock (clk), .reset (rst), .bus (sif));

    assign sif.start      = dif.start;
    assign sif.card_valid = dif.card_valid;
    assign sif.pscore     = dif.pscore;
    assign sif.dscore     = dif.dscore;
    assign sif.pcard3     = dif.pcard3;

    logic [5:0] strb;
    assign strb = {dif.load_dcard3, dif.load_pcard3, dif.load_dcard2,
                   dif.load_pcard2, dif.load_dcard1, dif.load_pcard1};

    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        #2;
        strobe_total += $countones(strb);
        if ($countones(strb) > 1) multi_strobe++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_round();
        @(negedge clk);
        dif.start = 1'b1;
        @(posedge clk);
        #1 dif.start = 1'b0;
    endtask

    // s is the slot index (P1=0..D3=5); scores are what the datapath shows after the load.
    task automatic deal(input int s, input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] p3);
        int n;
        logic [31:0] exp_strb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dif.card_req !== 1'b1 && n < 20);
        check("card_req", dif.card_req, 1);
        dif.card_valid = 1'b1;
        exp_strb = 32'd1 << s;
        #1 check("strobe", strb, exp_strb);
        @(posedge clk);
        #1;
        dif.card_valid = 1'b0;
        dif.pscore     = ps;
        dif.dscore     = ds;
        dif.pcard3     = p3;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dif.round_done !== 1'b1 && n < 20);
        check("round_done", dif.round_done, 1);
    endtask

    initial begin
        dif.start = 1'b0; dif.card_valid = 1'b0;
        dif.pscore = 4'd0; dif.dscore = 4'd0; dif.pcard3 = 4'd0;

        // Reset state, with card_valid offered while still in reset
        #12;
        dif.card_valid = 1'b1;
        #1;
        check("rst_card_req", dif.card_req, 0);
        check("rst_busy", dif.busy, 0);
        check("rst_strobes", strb, 0);
        check("rst_lights", {dif.player_win_light, dif.dealer_win_light}, 0);
        check("rst_rounds", dif.rounds, 0);
        @(negedge clk);
        dif.card_valid = 1'b0;
        rst = 1'b0;

        // Round 1: natural 8 vs 3
        snap = strobe_total;
        start_round();
        deal(0, 4'd1, 4'd0, 4'd0);
        deal(1, 4'd1, 4'd2, 4'd0);
        deal(2, 4'd8, 4'd2, 4'd0);
        deal(3, 4'd8, 4'd3, 4'd0);
        wait_done();
        check("r1_strobes", strobe_total - snap, 4);
        check("r1_lights", {dif.player_win_light, dif.dealer_win_light}, 2'b10);
        check("r1_player_wins", dif.player_wins, 1);
        check("r1_rounds", dif.rounds, 1);
        check("r1_dealer_ties", {dif.dealer_wins, dif.ties}, 0);
        @(negedge clk);
        check("r1_pulse_end", dif.round_done, 0);
        check("r1_no_req", dif.card_req, 0);

        // Round 2: start and card_valid together in DONE; player draws, dealer stands on 6
        snap = strobe_total;
        dif.start = 1'b1;
        dif.card_valid = 1'b1;
        #1 check("start_wins_strobe", strb, 0);
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.card_valid = 1'b0;
        check("r2_busy", dif.busy, 1);
        check("r2_lights_clr", {dif.player_win_light, dif.dealer_win_light}, 0);
        dif.pscore = 4'd0; dif.dscore = 4'd0;
        deal(0, 4'd2, 4'd0, 4'd0);
        deal(1, 4'd2, 4'd3, 4'd0);
        deal(2, 4'd4, 4'd3, 4'd0);
        deal(3, 4'd4, 4'd6, 4'd0);
        deal(4, 4'd9, 4'd6, 4'd5);
        wait_done();
        check("r2_strobes", strobe_total - snap, 5);
        check("r2_lights", {dif.player_win_light, dif.dealer_win_light}, 2'b10);
        check("r2_player_wins", dif.player_wins, 2);
        check("r2_rounds", dif.rounds, 2);

        // Round 3: both draw, 5/5 tie
        snap = strobe_total;
        start_round();
        deal(0, 4'd1, 4'd0, 4'd0);
        deal(1, 4'd1, 4'd1, 4'd0);
        deal(2, 4'd2, 4'd1, 4'd0);
        deal(3, 4'd2, 4'd3, 4'd0);
        deal(4, 4'd5, 4'd3, 4'd7);
        deal(5, 4'd5, 4'd5, 4'd7);
        wait_done();
        check("r3_strobes", strobe_total - snap, 6);
        check("r3_lights", {dif.player_win_light, dif.dealer_win_light}, 2'b11);
        check("r3_ties", dif.ties, 1);
        check("r3_rounds", dif.rounds, 3);
        check("r3_sat_rounds", sif.rounds, 3);
        check("r3_sat_player", sif.player_wins, 2);

        // Round 4: ten-cycle stall with a stray start, then reset after D1
        dif.pscore = 4'd0; dif.dscore = 4'd0;
        start_round();
        stall_ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dif.start = (i == 4);
            #1 if (dif.card_req === 1'b1 && strb === 6'd0) stall_ok++;
        end
        dif.start = 1'b0;
        check("stall_cycles", stall_ok, 10);
        snap = strobe_total;
        deal(0, 4'd3, 4'd0, 4'd0);
        deal(1, 4'd3, 4'd4, 4'd0);
        check("stall_single_strobe", strobe_total - snap, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", dif.busy, 0);
        check("mid_rst_req", dif.card_req, 0);
        check("mid_rst_tallies", {dif.player_wins, dif.dealer_wins, dif.ties, dif.rounds}, 0);
        check("mid_rst_sat_rounds", sif.rounds, 0);
        @(negedge clk);
        rst = 1'b0;
        dif.pscore = 4'd0; dif.dscore = 4'd0; dif.pcard3 = 4'd0;
        snap = strobe_total;
        dif.card_valid = 1'b1;
        repeat (3) @(negedge clk);
        dif.card_valid = 1'b0;
        check("idle_no_strobe", strobe_total - snap, 0);

        // Rounds 5..9: five dealer wins; TALLY_W=2 copy saturates at 3
        start_round();
        deal(0, 4'd1, 4'd0, 4'd0);
        deal(1, 4'd1, 4'd4, 4'd0);
        deal(2, 4'd1, 4'd4, 4'd0);
        deal(3, 4'd1, 4'd7, 4'd0);
        deal(4, 4'd1, 4'd7, 4'd0);
        wait_done();
        check("r5_lights", {dif.player_win_light, dif.dealer_win_light}, 2'b01);
        check("r5_dealer_wins", dif.dealer_wins, 1);
        check("r5_rounds", dif.rounds, 1);
        for (int k = 2; k <= 5; k++) begin
            dif.pscore = 4'd0; dif.dscore = 4'd0;
            start_round();
            deal(0, 4'd0, 4'd0, 4'd0);
            deal(1, 4'd0, 4'd4, 4'd0);
            deal(2, 4'd0, 4'd4, 4'd0);
            deal(3, 4'd0, 4'd9, 4'd0);
            wait_done();
            check("dealer_wins", dif.dealer_wins, k);
            check("sat_dealer_wins", sif.dealer_wins, (k > 3) ? 3 : k);
            check("sat_rounds", sif.rounds, (k > 3) ? 3 : k);
        end
        check("main_rounds", dif.rounds, 5);
        check("single_strobe", multi_strobe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
